// File: rtl/char_pkg.sv
// char_pkg: shared sizes, state encoding and default background colour for the
// glyph flusher and its scan counter.
package char_pkg;

  localparam int GLYPH_W  = 10;
  localparam int GLYPH_H  = 10;
  localparam int COLOUR_W = 6;
  localparam int COORD_W  = 8;

  localparam logic [COLOUR_W-1:0] BG_COLOUR = 6'b000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/char_scan_counter.sv
// char_scan_counter: row-major col/row walker over the glyph box.
// Exposes the next cell combinationally so the parent can register its query
// coordinates in lock-step with the counter, plus a flag for the final cell.
module char_scan_counter
  import char_pkg::*;
#(
  parameter int GLYPH_W = char_pkg::GLYPH_W,
  parameter int GLYPH_H = char_pkg::GLYPH_H
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_col_nxt,
  output logic [COORD_W-1:0] o_row_nxt,
  output logic               o_last
);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic               w_col_end;
  logic               w_row_end;

  assign w_col_end = (r_col == COORD_W'(GLYPH_W - 1));
  assign w_row_end = (r_row == COORD_W'(GLYPH_H - 1));
  assign o_last    = w_col_end && w_row_end;

  // Next cell in row-major order; wraps to (0,0) after the final cell.
  always_comb begin
    o_col_nxt = w_col_end ? '0 : r_col + COORD_W'(1);
    o_row_nxt = r_row;
    if (w_col_end) begin
      o_row_nxt = w_row_end ? '0 : r_row + COORD_W'(1);
    end
  end

  // Counter state: clear on a new glyph, step only when the scan advances.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      r_col <= o_col_nxt;
      r_row <= o_row_nxt;
    end
  end

endmodule

// File: rtl/char_flusher.sv
// char_flusher: walks a glyph box through a combinational glyph LUT and emits
// one-pixel write strobes to the VGA adapter.
// Build option: define CHAR_FLUSH_OPAQUE_EN to strobe every cell, writing
// BG_COLOUR for unlit cells (opaque draw); default is transparent draw.
module char_flusher
  import char_pkg::*;
#(
  parameter int                   GLYPH_W   = char_pkg::GLYPH_W,
  parameter int                   GLYPH_H   = char_pkg::GLYPH_H,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = char_pkg::BG_COLOUR
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [COORD_W-1:0]  char_x,
  input  logic [COORD_W-1:0]  char_y,
  input  logic                hold,
  input  logic [COLOUR_W-1:0] glyph_colour,
  input  logic                glyph_enable,
  output logic [COORD_W-1:0]  flush_x,
  output logic [COORD_W-1:0]  flush_y,
  output logic [COORD_W-1:0]  char_x_o,
  output logic [COORD_W-1:0]  char_y_o,
  output logic                plot,
  output logic [COORD_W-1:0]  plot_x,
  output logic [COORD_W-1:0]  plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                busy,
  output logic                done
);

`ifdef CHAR_FLUSH_OPAQUE_EN
  localparam bit OPAQUE = 1'b1;
`else
  localparam bit OPAQUE = 1'b0;
`endif

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [COORD_W-1:0]  r_org_x;
  logic [COORD_W-1:0]  r_org_y;
  logic [COORD_W-1:0]  r_flush_x;
  logic [COORD_W-1:0]  r_flush_y;
  logic                r_pend_valid;
  logic                r_pend_en;
  logic [COORD_W-1:0]  r_pend_x;
  logic [COORD_W-1:0]  r_pend_y;
  logic [COLOUR_W-1:0] r_pend_colour;

  logic                w_accept;
  logic                w_scan_adv;
  logic                w_drain_adv;
  logic                w_last;
  logic [COORD_W-1:0]  w_col_nxt;
  logic [COORD_W-1:0]  w_row_nxt;
  logic                w_cell_en;
  logic [COLOUR_W-1:0] w_cell_colour;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_scan_adv  = (r_state == SCAN) && !hold;
  assign w_drain_adv = (r_state == DRAIN) && !hold;

  // In opaque mode every cell writes; unlit cells take the background colour.
  assign w_cell_en     = glyph_enable || OPAQUE;
  assign w_cell_colour = (glyph_enable || !OPAQUE) ? glyph_colour : BG_COLOUR;

  char_scan_counter #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H)
  ) u_scan (
    .i_clk     (clock),
    .i_rst_n   (resetn),
    .i_clear   (w_accept),
    .i_en      (w_scan_adv),
    .o_col_nxt (w_col_nxt),
    .o_row_nxt (w_row_nxt),
    .o_last    (w_last)
  );

  // State sequencing with registered busy/done and the latched origin.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_org_x <= '0;
      r_org_y <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_org_x <= char_x;
            r_org_y <= char_y;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (!hold && w_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!hold) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Query registers and the one-deep pixel pipeline; both freeze under hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_flush_x     <= '0;
      r_flush_y     <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_en     <= 1'b0;
      r_pend_x      <= '0;
      r_pend_y      <= '0;
      r_pend_colour <= '0;
    end else if (w_accept) begin
      r_flush_x    <= char_x;
      r_flush_y    <= char_y;
      r_pend_valid <= 1'b0;
    end else if (w_scan_adv) begin
      r_flush_x     <= r_org_x + w_col_nxt;
      r_flush_y     <= r_org_y + w_row_nxt;
      r_pend_valid  <= 1'b1;
      r_pend_en     <= w_cell_en;
      r_pend_x      <= r_flush_x;
      r_pend_y      <= r_flush_y;
      r_pend_colour <= w_cell_colour;
    end else if (w_drain_adv) begin
      r_pend_valid <= 1'b0;
    end
  end

  assign flush_x     = r_flush_x;
  assign flush_y     = r_flush_y;
  assign char_x_o    = r_org_x;
  assign char_y_o    = r_org_y;
  assign plot        = r_pend_valid && r_pend_en && !hold;
  assign plot_x      = r_pend_x;
  assign plot_y      = r_pend_y;
  assign plot_colour = r_pend_colour;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: doc/char_flusher.md
Name: char_flusher

Overview:
- Sequencer on the consumer side of the glyph-decoder interface.
- On `start`, it latches a character origin, then walks every cell of the glyph box by driving `flush_x`/`flush_y` into any char glyph LUT module (`char_c` etc.).
- It samples the returned `colour`/`enable` and emits one-pixel write strobes to the VGA adapter.
- It sits between the game-object renderer and the VGA adapter; one instance is shared across all glyph LUTs through a mux upstream.

Parameters:
- GLYPH_W, 10, glyph box width in pixels (columns 0..GLYPH_W-1).
- GLYPH_H, 10, glyph box height in pixels (rows 0..GLYPH_H-1).
- BG_COLOUR, 6'b000000, colour written for unlit cells when opaque mode is compiled in.

Ports:
- `clock` in 1: system clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request to draw one glyph; sampled only in IDLE.
- `char_x` in 8: glyph origin x; latched on an accepted start.
- `char_y` in 8: glyph origin y; latched on an accepted start.
- `hold` in 1: VGA back-pressure; freezes scan and pipeline while high.
- `glyph_colour` in 6: colour from the glyph LUT for the current `flush_x`/`flush_y`.
- `glyph_enable` in 1: lit flag from the glyph LUT for the current `flush_x`/`flush_y`.
- `flush_x` out 8: query x, equal to origin_x + col, modulo 256.
- `flush_y` out 8: query y, equal to origin_y + row, modulo 256.
- `char_x_o` out 8: latched origin x, routed to the LUT `x` input.
- `char_y_o` out 8: latched origin y, routed to the LUT `y` input.
- `plot` out 1: pixel write strobe to the VGA adapter.
- `plot_x` out 8: write x coordinate.
- `plot_y` out 8: write y coordinate.
- `plot_colour` out 6: write colour.
- `busy` out 1: high from the cycle after start acceptance until `done`.
- `done` out 1: single-cycle completion pulse.

Behaviour:
- Reset:
  - Asynchronous on `resetn`=0, including mid-draw.
  - State goes to IDLE; col, row and all outputs go to 0.
  - No partial strobe is emitted after reset.
- IDLE:
  - `busy`=0, `plot`=0.
  - `start`=1 latches origin, clears col/row, moves to SCAN.
  - `start` in any other state is ignored (no queueing).
- SCAN, per non-hold cycle:
  - `flush_x`/`flush_y` are registered and reflect the current col/row.
  - The LUT answers combinationally in the same cycle.
  - The answer is captured into a one-deep pipeline register (pending_valid, x, y, colour).
  - col increments; at GLYPH_W-1 col wraps to 0 and row increments.
  - Row-major order: x fastest.
- SCAN exit: after issuing col=GLYPH_W-1, row=GLYPH_H-1, go to DRAIN.
- DRAIN: one cycle presents the final pipeline entry, then go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0 in that cycle, then IDLE.
- Latency:
  - First strobe can appear 2 cycles after the `start` edge.
  - With `hold` never asserted, `done` pulses exactly GLYPH_W*GLYPH_H+2 cycles after start acceptance.
- Plot rule: `plot` = pending_valid & pending_enable & ~`hold`; without opaque mode, unlit cells produce no strobe.
- `hold` behaviour:
  - While high, col/row, the `flush_*` registers, the pipeline register and the state do not advance.
  - `plot` is forced to 0.
  - The pending pixel is re-presented when `hold` drops; no pixel is lost or duplicated.
  - `hold` in IDLE or DONE has no effect.
- Arithmetic:
  - Coordinates are 8-bit unsigned; origin+offset wraps modulo 256.
  - Wrapped pixels are still plotted; clipping is the adapter's job.
- Origin stability: `char_x_o`/`char_y_o` stay stable for the whole draw; changing `char_x`/`char_y` mid-draw has no effect.

Optional Feature:
- Macro: CHAR_FLUSH_OPAQUE_EN.
- Defined: every cell strobes `plot`; unlit cells write BG_COLOUR, so GLYPH_W*GLYPH_H writes per glyph, which erases the previous glyph in place.
- Undefined: only `glyph_enable`=1 cells strobe (transparent draw).

Decomposition:
- Package `char_pkg` holds:
  - GLYPH_W, GLYPH_H, COLOUR_W=6 and COORD_W=8.
  - The state enum {IDLE, SCAN, DRAIN, DONE}.
  - The BG_COLOUR default.
- Sub-module `char_scan_counter`: col/row counter with enable, wrap, and a `last` flag; this keeps the FSM to state sequencing only.

Test Plan:
- Transparent draw with the `char_c` LUT, origin (20,30), no hold:
  - 26 strobes total.
  - First strobe at (23,30); last strobe at (27,39).
  - `done` exactly 102 cycles after start; no strobe at the empty cell (24,31).
- Opaque build, same stimulus:
  - 100 strobes.
  - Cell (20,30) written with colour 0; cell (23,30) written with 6'h3F.
- `hold` high for 5 cycles while the pixel at (26,30) is pending:
  - No strobes during hold.
  - (26,30) strobed once after release.
  - `done` delayed by exactly 5 cycles.
- Origin (250,250):
  - The pixel from `char_c` row 0 col 3 plots at (253,250).
  - The col 8 row 2 pixel wraps to (2,252) and is still strobed.
- `start` re-pulsed at cycle 40 of a draw: ignored; a single `done` at cycle 102 with an unchanged strobe count.
- `resetn` dropped at cycle 50: outputs go to 0 asynchronously; a new start after release draws a complete glyph from (0,0) offset.
